// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-side memory responder.
// MMIO offsets, STATUS layout and the byte-lane merge used everywhere.
package dmem_pkg;

    localparam logic [27:0] OFF_TIME_LO = 28'h000_0000;
    localparam logic [27:0] OFF_TIME_HI = 28'h000_0004;
    localparam logic [27:0] OFF_TXDATA  = 28'h000_0010;
    localparam logic [27:0] OFF_STATUS  = 28'h000_0014;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_CNT   = 4;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_responder_tx_byte_fifo.sv
// Console TX byte FIFO with sticky overflow flag.
// A push into a full FIFO succeeds only if a pop frees a slot that cycle.
module tx_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    input  logic       ovf_clr,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic [4:0] count,
    output logic       overflow
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == 5'd0);
    assign full    = (count == 5'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? 8'h00 : mem_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr] <= din;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + 5'(do_push) - 5'(do_pop);
            // a dropped byte outranks a same-cycle clear
            if (push && !do_push) overflow <= 1'b1;
            else if (ovf_clr)     overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data memory responder: byte-strobed RAM plus timer/console MMIO window.
// Define DMEM_TIMER_EN to build the 64-bit cycle timer.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter int          TXF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_raddr,
    input  logic        data_re,
    output logic [31:0] data_rdata,
    input  logic [31:0] data_waddr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    input  logic        data_we,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   mem [MEM_WORDS];
    logic          rd_mmio;
    logic          wr_mmio;
    logic [27:0]   roff;
    logic [27:0]   woff;
    logic [AW-1:0] ridx;
    logic [AW-1:0] widx;
    logic          ram_we;
    logic          tx_push;
    logic          ovf_clr;
    logic [31:0]   rd_next;
    logic [31:0]   status;
    logic [31:0]   time_lo_rd;
    logic [31:0]   time_hi_rd;
    logic          f_full;
    logic          f_empty;
    logic          f_ovf;
    logic [4:0]    f_count;
    logic          unused_addr;

    assign unused_addr = ^{data_raddr[1:0], data_waddr[1:0]};

    assign rd_mmio = (data_raddr[31:28] == MMIO_BASE[31:28]);
    assign wr_mmio = (data_waddr[31:28] == MMIO_BASE[31:28]);
    assign roff    = {data_raddr[27:2], 2'b00};
    assign woff    = {data_waddr[27:2], 2'b00};
    assign ridx    = data_raddr[AW+1:2];
    assign widx    = data_waddr[AW+1:2];

    assign ram_we  = data_we && !wr_mmio;
    assign tx_push = data_we && wr_mmio && (woff == OFF_TXDATA) && data_wstrb[0];
    assign ovf_clr = data_we && wr_mmio && (woff == OFF_STATUS) &&
                     data_wstrb[0] && data_wdata[ST_OVF];

    tx_byte_fifo #(
        .DEPTH(TXF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (tx_push),
        .din     (data_wdata[7:0]),
        .pop     (tx_valid && tx_ready),
        .ovf_clr (ovf_clr),
        .dout    (tx_data),
        .full    (f_full),
        .empty   (f_empty),
        .count   (f_count),
        .overflow(f_ovf)
    );

    assign tx_valid = !f_empty;

    always_comb begin
        status           = '0;
        status[ST_EMPTY] = f_empty;
        status[ST_FULL]  = f_full;
        status[ST_OVF]   = f_ovf;
        status[ST_CNT +: 5] = f_count;
    end

`ifdef DMEM_TIMER_EN
    logic [63:0] timer_q;
    logic [63:0] timer_inc;
    logic [31:0] hi_shadow;
    logic        wr_lo;
    logic        wr_hi;
    logic        rd_lo;

    assign timer_inc = timer_q + 64'd1;
    assign wr_lo = data_we && wr_mmio && (woff == OFF_TIME_LO);
    assign wr_hi = data_we && wr_mmio && (woff == OFF_TIME_HI);
    assign rd_lo = data_re && rd_mmio && (roff == OFF_TIME_LO);

    // written lanes replace the incremented value for that half
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q   <= '0;
            hi_shadow <= '0;
        end else begin
            timer_q[31:0] <= wr_lo ?
                byte_merge(timer_inc[31:0], data_wdata, data_wstrb) :
                timer_inc[31:0];
            timer_q[63:32] <= wr_hi ?
                byte_merge(timer_inc[63:32], data_wdata, data_wstrb) :
                timer_inc[63:32];
            if (rd_lo) hi_shadow <= timer_q[63:32];
        end
    end

    assign time_lo_rd = wr_lo ?
        byte_merge(timer_q[31:0], data_wdata, data_wstrb) : timer_q[31:0];
    assign time_hi_rd = wr_hi ?
        byte_merge(hi_shadow, data_wdata, data_wstrb) : hi_shadow;
`else
    assign time_lo_rd = '0;
    assign time_hi_rd = '0;
`endif

    always_comb begin
        rd_next = '0;
        if (!rd_mmio) begin
            rd_next = mem[ridx];
            if (ram_we && (widx == ridx))
                rd_next = byte_merge(mem[ridx], data_wdata, data_wstrb);
        end else begin
            unique case (1'b1)
                (roff == OFF_TIME_LO): rd_next = time_lo_rd;
                (roff == OFF_TIME_HI): rd_next = time_hi_rd;
                (roff == OFF_STATUS):  rd_next = status;
                default:               rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) data_rdata <= '0;
        else if (data_re) data_rdata <= rd_next;
    end

    always_ff @(posedge clk) begin
        if (rst_n && ram_we)
            mem[widx] <= byte_merge(mem[widx], data_wdata, data_wstrb);
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-side memory responder for the pipelined RV32 core. It is the slave end of the core's data memory interface (data_raddr/data_re/data_rdata, data_waddr/data_wdata/data_wstrb/data_we).
- Serves a byte-strobed word RAM.
- Serves a small MMIO window: a 64-bit cycle timer and a console TX byte FIFO drained over a valid/ready handshake.
- Sits beside the core top in the SoC/testbench wrapper.

Parameters:
MEM_WORDS, 4096, RAM depth in 32-bit words; power of two.
MMIO_BASE, 32'h1000_0000, MMIO window base; decode on addr[31:28] only.
TXF_DEPTH, 4, TX FIFO depth; power of two, 2..16.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
data_raddr  in  32  read byte address; word-aligned, bits[1:0] ignored
data_re  in  1  read enable
data_rdata  out  32  registered read data
data_waddr  in  32  write byte address; bits[1:0] ignored
data_wdata  in  32  write data
data_wstrb  in  4  byte-lane write strobes; bit n = bits[8n+7:8n]
data_we  in  1  write enable
tx_valid  out  1  TX FIFO non-empty
tx_data  out  8  FIFO head byte
tx_ready  in  1  consumer accepts head

Behaviour:
- Reset:
  - data_rdata=0, tx_valid=0, tx_data=0.
  - FIFO pointers and count=0, overflow=0, timer=0, hi_shadow=0.
  - RAM contents are not reset. Reset asserted mid-operation overrides any concurrent read, write, push or pop that cycle.
- Decode: MMIO when addr[31:28]==MMIO_BASE[31:28]; otherwise RAM.
  - RAM index = addr[log2(MEM_WORDS)+1:2]; upper bits alias (wrap).
- MMIO map (offset from MMIO_BASE):
  - 0x00 TIME_LO
  - 0x04 TIME_HI
  - 0x10 TXDATA (write-only, reads 0)
  - 0x14 STATUS: bit0 empty, bit1 full, bit2 overflow, bits[8:4] count, rest 0.
  - Unmapped offsets read 0; writes to them are ignored.
- Read timing: data_re sampled at posedge; data_rdata valid the following cycle (1-cycle latency). data_rdata holds its last value while data_re=0.
- Write: committed at posedge when data_we=1; only strobed lanes change. data_wstrb=0 is a no-op.
- Same-cycle read and write to the same word (RAM or timer): data_rdata returns the merged new value (write-first).
- Timer:
  - 64-bit counter increments by 1 every cycle and wraps at 2^64-1 to 0.
  - A TIME_LO/TIME_HI write replaces the strobed bytes that cycle; the write wins over the increment for that half.
  - A TIME_LO read snapshots the current upper 32 bits into hi_shadow. A TIME_HI read returns hi_shadow, so a LO-then-HI pair is coherent.
- TX FIFO:
  - Push on a TXDATA write with wstrb[0]=1, storing wdata[7:0].
  - Pop when tx_valid && tx_ready.
  - tx_data = head, combinational from storage. tx_valid = count!=0.
  - Push while full and no pop: byte dropped, overflow set (sticky).
  - Push and pop in the same cycle: both succeed, including when full; count unchanged.
  - Pop when empty is impossible since tx_valid=0.
  - Overflow clears on a STATUS write with wstrb[0]=1 and wdata[2]=1.
  - STATUS reads reflect state before the same-cycle write.

Optional Feature:
DMEM_TIMER_EN.
- Defined: timer and hi_shadow are present as described.
- Undefined: no timer logic; TIME_LO/TIME_HI read 0; writes to them are ignored.

Decomposition:
- Package dmem_pkg:
  - MMIO offset constants (OFF_TIME_LO, OFF_TIME_HI, OFF_TXDATA, OFF_STATUS).
  - STATUS bit positions.
  - Helper to byte-merge wdata into a word under wstrb, shared by RAM, timer and bypass.
- Sub-module tx_byte_fifo (parameter DEPTH): push/pop/full/empty/count/overflow. It is instantiated once.

Test Plan:
- RAM write/readback: write 0xDEADBEEF strb 4'hF to 0x0000_0040, read same address next cycle -> data_rdata=0xDEADBEEF one cycle after data_re.
- Byte strobes: prior word 0x11223344, write 0xAABBCCDD strb 4'b0101 -> read 0x11BB33DD. Same-cycle read+write of that word also returns 0x11BB33DD.
- Alias and reset: write 0x5 to word index MEM_WORDS+3 -> read at index 3 returns 0x5. Assert rst_n=0 for one cycle mid-stream -> data_rdata=0, tx_valid=0, STATUS reads 0x1.
- FIFO full/overflow:
  - Push 0x41..0x45 with tx_ready=0 -> STATUS=0x46 (count 4, full, overflow); tx_data=0x41.
  - Raise tx_ready -> bytes 0x41..0x44 emerge in order, then tx_valid=0.
  - STATUS write 0x4 -> overflow cleared.
- Full push+pop: FIFO full with tx_ready=1 and a push of 0x55 the same cycle -> count stays 4, no overflow, 0x55 is last out.
- Timer (DMEM_TIMER_EN): write TIME_LO=0xFFFF_FFFE, TIME_HI=0 -> after 3 cycles reading LO then HI gives a coherent pair with HI=1. Without the macro both read 0.
